array_output_fifo: RTL and testbench

Parametrised multi-port collection FIFO between the systolic array's output columns and the single quantize/activate unit. Each cycle it accepts up to NUM_IN unquantized int32 results with row/col tags, packs the valid ones in port order, and drains them one per cycle over a valid/ready handshake. Its `in_ready` backpressure and sticky drop flag let the array controller stall instead of silently losing results.

---
 rtl/array_output_fifo_pkg.sv | 30 +++
 rtl/array_output_fifo_port_compactor.sv | 45 ++++
 rtl/array_output_fifo.sv | 175 +++++++++++++++++
 tb/tb_array_output_fifo.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/array_output_fifo_pkg.sv
// -----------------------------------------------------------------------------
// array_output_fifo_pkg
// Shared types for the systolic-array output path:
//   int32_t  - unquantized accumulator result
//   coord_t  - row/col tag sized for the default maximum matrix dimension
//   entry_t  - {value, row, col} record, reused by the quantizer
// Also holds a width helper used by the FIFO and its port compactor.
// No ports (package).
// -----------------------------------------------------------------------------
package array_output_fifo_pkg;

  typedef logic signed [31:0] int32_t;

  localparam int SYS_MAX_N   = 16;
  localparam int SYS_COORD_W = $clog2(SYS_MAX_N);

  typedef logic [SYS_COORD_W-1:0] coord_t;

  typedef struct packed {
    int32_t value;
    coord_t row;
    coord_t col;
  } entry_t;

  // Index width that never collapses to zero bits for single-element ranges.
  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/array_output_fifo_port_compactor.sv
// -----------------------------------------------------------------------------
// port_compactor
// Purely combinational. Given the per-port valid vector and an optional port to
// skip (the one consumed by bypass), reports which ports are to be stored,
// each port's slot offset relative to the write pointer (ports packed in
// ascending index order), and the total number stored.
// Ports:
//   i_valid     [NUM_IN]   per-port valid
//   i_skip_en   1          exclude port i_skip_idx from storage
//   i_skip_idx  IDX_W      port to exclude
//   o_keep      [NUM_IN]   port is stored
//   o_offset    OFF_W each slot offset of each port (meaningful when o_keep)
//   o_stored    OFF_W      popcount of o_keep
// -----------------------------------------------------------------------------
module port_compactor
  import array_output_fifo_pkg::*;
#(
  parameter int NUM_IN = 4,
  parameter int IDX_W  = clog2_min1(NUM_IN),
  parameter int OFF_W  = $clog2(NUM_IN + 1)
) (
  input  logic [NUM_IN-1:0] i_valid,
  input  logic              i_skip_en,
  input  logic [IDX_W-1:0]  i_skip_idx,
  output logic [NUM_IN-1:0] o_keep,
  output logic [OFF_W-1:0]  o_offset [NUM_IN],
  output logic [OFF_W-1:0]  o_stored
);

  logic [OFF_W-1:0] w_acc;

  // Running prefix count: each kept port lands right after the kept ports
  // below it.
  always_comb begin
    w_acc  = '0;
    o_keep = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      o_keep[i]   = i_valid[i] && !(i_skip_en && (i_skip_idx == IDX_W'(i)));
      o_offset[i] = w_acc;
      if (o_keep[i]) w_acc = w_acc + OFF_W'(1);
    end
    o_stored = w_acc;
  end

endmodule

// File: rtl/array_output_fifo.sv
// -----------------------------------------------------------------------------
// array_output_fifo
// Multi-port collection FIFO between the systolic array output columns and the
// single quantize/activate unit. Up to NUM_IN tagged int32 results per cycle
// are packed in port order into a circular buffer and drained one per cycle.
// in_ready depends only on the registered occupancy, so the array controller
// can stall; a valid input arriving while in_ready=0 sets the sticky drop_err.
//
// Optional feature: define ARRAY_OUTPUT_FIFO_BYPASS_EN to let the lowest valid
// input port go straight to the output when the FIFO is empty and the
// consumer is ready (0-cycle latency). Undefined: minimum latency 1 cycle and
// no input-to-output combinational path.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   flush                 discard all stored entries (beats writes and pops)
//   in_valid[NUM_IN]      per-port result valid
//   in_output[NUM_IN]     int32 results
//   in_row/in_col[NUM_IN] matrix coordinates
//   in_ready              a full NUM_IN group fits this cycle
//   out_valid/out_output/out_row/out_col  head entry (zero when not valid)
//   out_ready             consumer takes head
//   count                 registered occupancy
//   drop_err              sticky drop indicator, cleared only by reset
// -----------------------------------------------------------------------------
module array_output_fifo
  import array_output_fifo_pkg::*;
#(
  parameter int NUM_IN   = 4,
  parameter int DEPTH    = 8,
  parameter int MAX_N    = 16,
  parameter int N_BITS   = $clog2(MAX_N),
  parameter int CNT_BITS = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic [NUM_IN-1:0] in_valid,
  input  int32_t            in_output [NUM_IN],
  input  logic [N_BITS-1:0] in_row    [NUM_IN],
  input  logic [N_BITS-1:0] in_col    [NUM_IN],
  output logic              in_ready,
  output logic              out_valid,
  output int32_t            out_output,
  output logic [N_BITS-1:0] out_row,
  output logic [N_BITS-1:0] out_col,
  input  logic              out_ready,
  output logic [CNT_BITS-1:0] count,
  output logic              drop_err
);

  localparam int PTR_W = clog2_min1(DEPTH);
  localparam int IDX_W = clog2_min1(NUM_IN);
  localparam int OFF_W = $clog2(NUM_IN + 1);
  localparam int SUM_W = CNT_BITS + 1;

  // Storage payload (never reset)
  int32_t            r_mem_val [DEPTH];
  logic [N_BITS-1:0] r_mem_row [DEPTH];
  logic [N_BITS-1:0] r_mem_col [DEPTH];

  // Control state
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [CNT_BITS-1:0] r_count;
  logic                r_drop_err;

  logic                w_in_ready;
  logic                w_any_valid;
  logic [IDX_W-1:0]    w_low_idx;
  logic                w_bypass;
  logic                w_write_en;
  logic                w_pop;
  logic                w_drop;
  logic [NUM_IN-1:0]   w_keep;
  logic [OFF_W-1:0]    w_offset [NUM_IN];
  logic [OFF_W-1:0]    w_comp_stored;
  logic [OFF_W-1:0]    w_stored;
  logic [SUM_W-1:0]    w_count_sum;

  // Free space check on registered occupancy only; a same-cycle pop is ignored.
  assign w_in_ready = (SUM_W'(DEPTH) - {1'b0, r_count}) >= SUM_W'(NUM_IN);

  // Lowest-index valid port (bypass candidate).
  always_comb begin
    w_low_idx   = '0;
    w_any_valid = |in_valid;
    for (int i = NUM_IN - 1; i >= 0; i--) begin
      if (in_valid[i]) w_low_idx = IDX_W'(i);
    end
  end

`ifdef ARRAY_OUTPUT_FIFO_BYPASS_EN
  assign w_bypass = (r_count == '0) && out_ready && w_any_valid && w_in_ready && !flush;
`else
  assign w_bypass = 1'b0;
`endif

  port_compactor #(
    .NUM_IN (NUM_IN),
    .IDX_W  (IDX_W),
    .OFF_W  (OFF_W)
  ) u_port_compactor (
    .i_valid    (in_valid),
    .i_skip_en  (w_bypass),
    .i_skip_idx (w_low_idx),
    .o_keep     (w_keep),
    .o_offset   (w_offset),
    .o_stored   (w_comp_stored)
  );

  assign w_write_en = w_in_ready && !flush;
  assign w_stored   = w_write_en ? w_comp_stored : '0;
  assign w_drop     = w_any_valid && !w_in_ready && !flush;

  // Head presentation: bypassed input, else registered-index storage read.
  always_comb begin
    out_valid  = w_bypass || (r_count != '0);
    out_output = '0;
    out_row    = '0;
    out_col    = '0;
    if (w_bypass) begin
      out_output = in_output[w_low_idx];
      out_row    = in_row[w_low_idx];
      out_col    = in_col[w_low_idx];
    end else if (r_count != '0) begin
      out_output = r_mem_val[r_rd_ptr];
      out_row    = r_mem_row[r_rd_ptr];
      out_col    = r_mem_col[r_rd_ptr];
    end
  end

  // A bypassed entry is consumed without touching storage or rd_ptr.
  assign w_pop       = out_valid && out_ready && !w_bypass;
  assign w_count_sum = {1'b0, r_count} + SUM_W'(w_stored) - SUM_W'(w_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_drop_err <= 1'b0;
    end else begin
      if (w_drop) r_drop_err <= 1'b1;
      if (flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(w_stored);
        r_rd_ptr <= r_rd_ptr + PTR_W'(w_pop);
        r_count  <= w_count_sum[CNT_BITS-1:0];
      end
    end
  end

  // Compacted payload write; slot indices wrap because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_IN; i++) begin
      if (w_write_en && w_keep[i]) begin
        r_mem_val[r_wr_ptr + PTR_W'(w_offset[i])] <= in_output[i];
        r_mem_row[r_wr_ptr + PTR_W'(w_offset[i])] <= in_row[i];
        r_mem_col[r_wr_ptr + PTR_W'(w_offset[i])] <= in_col[i];
      end
    end
  end

  a_count_bound: assert property (@(posedge clk) disable iff (reset)
    w_count_sum <= SUM_W'(DEPTH));

  assign in_ready = w_in_ready;
  assign count    = r_count;
  assign drop_err = r_drop_err;

endmodule

// File: tb/tb_array_output_fifo.sv
module tb_array_output_fifo;

  localparam int NUM_IN   = 4;
  localparam int DEPTH    = 8;
  localparam int N_BITS   = 4;
  localparam int CNT_BITS = 4;

  logic                clk = 1'b0;
  logic                reset;
  logic                flush;
  logic [NUM_IN-1:0]   in_valid;
  logic signed [31:0]  in_output [NUM_IN];
  logic [N_BITS-1:0]   in_row    [NUM_IN];
  logic [N_BITS-1:0]   in_col    [NUM_IN];
  logic                in_ready;
  logic                out_valid;
  logic signed [31:0]  out_output;
  logic [N_BITS-1:0]   out_row;
  logic [N_BITS-1:0]   out_col;
  logic                out_ready;
  logic [CNT_BITS-1:0] count;
  logic                drop_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  array_output_fifo #(
    .NUM_IN (NUM_IN),
    .DEPTH  (DEPTH),
    .MAX_N  (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_output  (in_output),
    .in_row     (in_row),
    .in_col     (in_col),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_output (out_output),
    .out_row    (out_row),
    .out_col    (out_col),
    .out_ready  (out_ready),
    .count      (count),
    .drop_err   (drop_err)
  );

  task automatic clear_inputs();
    in_valid = '0;
    flush    = 1'b0;
    for (int i = 0; i < NUM_IN; i++) begin
      in_output[i] = '0;
      in_row[i]    = '0;
      in_col[i]    = '0;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; out_ready = 1'b0; clear_inputs();
    repeat (2) cyc();
    reset = 1'b0; #1;
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b expected 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid); end
    checks++; if (out_output !== 32'sd0) begin errors++; $display("FAIL reset_out_output: got %0h expected 0", out_output); end
    checks++; if (drop_err !== 1'b0) begin errors++; $display("FAIL reset_drop_err: got %0b expected 0", drop_err); end
  endtask

  task automatic test_single_write();
    out_ready = 1'b0;
    in_valid = 4'b0100; in_output[2] = 32'sh0000_1234; in_row[2] = 4'd3; in_col[2] = 4'd5;
    cyc(); clear_inputs(); #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %0b expected 1", out_valid); end
    checks++; if (out_output !== 32'sh1234) begin errors++; $display("FAIL single_value: got %0h expected 1234", out_output); end
    checks++; if (out_row !== 4'd3) begin errors++; $display("FAIL single_row: got %0d expected 3", out_row); end
    checks++; if (out_col !== 4'd5) begin errors++; $display("FAIL single_col: got %0d expected 5", out_col); end
    checks++; if (count !== 4'd1) begin errors++; $display("FAIL single_count: got %0d expected 1", count); end
    out_ready = 1'b1; cyc(); out_ready = 1'b0; #1;
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL single_pop_count: got %0d expected 0", count); end
    checks++; if (out_valid !== 1'b0 || out_output !== 32'sd0) begin errors++; $display("FAIL single_pop_idle: got v=%0b d=%0h expected v=0 d=0", out_valid, out_output); end
  endtask

  task automatic test_compaction();
    out_ready = 1'b0;
    in_valid = 4'b1001; in_output[0] = 32'sd10; in_output[3] = 32'sd30; in_row[3] = 4'd7;
    cyc(); clear_inputs(); #1;
    checks++; if (count !== 4'd2) begin errors++; $display("FAIL compact_count2: got %0d expected 2", count); end
    checks++; if (out_output !== 32'sd10) begin errors++; $display("FAIL compact_first: got %0d expected 10", out_output); end
    out_ready = 1'b1; cyc(); #1;
    checks++; if (count !== 4'd1) begin errors++; $display("FAIL compact_count1: got %0d expected 1", count); end
    checks++; if (out_output !== 32'sd30 || out_row !== 4'd7) begin errors++; $display("FAIL compact_second: got %0d row %0d expected 30 row 7", out_output, out_row); end
    cyc(); #1;
    checks++; if (count !== 4'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL compact_empty: got count %0d valid %0b expected 0 0", count, out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid = 4'b1111; for (int i = 0; i < NUM_IN; i++) in_output[i] = 100 + i;
    cyc();
    for (int i = 0; i < NUM_IN; i++) in_output[i] = 104 + i;
    cyc(); clear_inputs(); #1;
    checks++; if (count !== 4'd8) begin errors++; $display("FAIL bp_full_count: got %0d expected 8", count); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready: got %0b expected 0", in_ready); end
    checks++; if (drop_err !== 1'b0) begin errors++; $display("FAIL bp_no_drop_yet: got %0b expected 0", drop_err); end
    in_valid = 4'b0001; in_output[0] = 32'sd999;
    cyc(); clear_inputs(); #1;
    checks++; if (drop_err !== 1'b1) begin errors++; $display("FAIL bp_drop_err: got %0b expected 1", drop_err); end
    checks++; if (count !== 4'd8) begin errors++; $display("FAIL bp_drop_count: got %0d expected 8", count); end
    out_ready = 1'b1; cyc(); out_ready = 1'b0; #1;
    checks++; if (count !== 4'd7) begin errors++; $display("FAIL bp_pop_count: got %0d expected 7", count); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_pop_ready: got %0b expected 0", in_ready); end
    out_ready = 1'b1;
    for (int k = 1; k < 8; k++) begin
      checks++; if (out_output !== 32'(100 + k)) begin errors++; $display("FAIL bp_drain_%0d: got %0d expected %0d", k, out_output, 100 + k); end
      cyc();
    end
    out_ready = 1'b0; #1;
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL bp_drained: got %0d expected 0", count); end
    checks++; if (drop_err !== 1'b1) begin errors++; $display("FAIL bp_drop_sticky: got %0b expected 1", drop_err); end
  endtask

  task automatic test_mid_reset();
    out_ready = 1'b0;
    in_valid = 4'b1111; for (int i = 0; i < NUM_IN; i++) in_output[i] = 50 + i;
    cyc(); clear_inputs();
    reset = 1'b1; cyc(); reset = 1'b0; #1;
    checks++; if (count !== 4'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL midrst_state: got count %0d valid %0b expected 0 0", count, out_valid); end
    checks++; if (drop_err !== 1'b0) begin errors++; $display("FAIL midrst_drop: got %0b expected 0", drop_err); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %0b expected 1", in_ready); end
  endtask

  task automatic test_wraparound();
    int q[$];
    int next_val;
    int max_count;
    next_val = 1000; max_count = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      clear_inputs();
      if (in_ready) begin
        in_valid = 4'b0111;
        for (int p = 0; p < 3; p++) begin
          in_output[p] = next_val; in_row[p] = 4'(next_val); q.push_back(next_val); next_val++;
        end
      end
      #1;
      if (out_valid) begin
        checks++;
        if (q.size() == 0) begin errors++; $display("FAIL wrap_unexpected: got %0d expected no output", out_output); end
        else begin
          if (out_output !== 32'(q[0])) begin errors++; $display("FAIL wrap_order: got %0d expected %0d", out_output, q[0]); end
          void'(q.pop_front());
        end
      end
      if (int'(count) > max_count) max_count = int'(count);
      cyc();
    end
    clear_inputs();
    for (int k = 0; k < 40 && q.size() > 0; k++) begin
      #1;
      if (out_valid) begin
        checks++; if (out_output !== 32'(q[0])) begin errors++; $display("FAIL wrap_drain: got %0d expected %0d", out_output, q[0]); end
        void'(q.pop_front());
      end
      if (int'(count) > max_count) max_count = int'(count);
      cyc();
    end
    out_ready = 1'b0; #1;
    checks++; if (q.size() != 0) begin errors++; $display("FAIL wrap_timeout: got %0d pending expected 0", q.size()); end
    checks++; if (max_count > DEPTH) begin errors++; $display("FAIL wrap_max_count: got %0d expected <= %0d", max_count, DEPTH); end
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL wrap_final_count: got %0d expected 0", count); end
    checks++; if (drop_err !== 1'b0) begin errors++; $display("FAIL wrap_drop: got %0b expected 0", drop_err); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid = 4'b1111; for (int i = 0; i < NUM_IN; i++) in_output[i] = 200 + i;
    cyc(); clear_inputs();
    in_valid = 4'b0001; in_output[0] = 32'sd204;
    cyc(); clear_inputs(); #1;
    checks++; if (count !== 4'd5) begin errors++; $display("FAIL flush_pre_count: got %0d expected 5", count); end
    flush = 1'b1; in_valid = 4'b0011; in_output[0] = 32'sd300; in_output[1] = 32'sd301; out_ready = 1'b1;
    cyc(); clear_inputs(); out_ready = 1'b0; #1;
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL flush_count: got %0d expected 0", count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %0b expected 0", out_valid); end
    checks++; if (drop_err !== 1'b0) begin errors++; $display("FAIL flush_drop: got %0b expected 0", drop_err); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_ready: got %0b expected 1", in_ready); end
  endtask

  task automatic test_bypass();
    clear_inputs(); out_ready = 1'b1;
    in_valid = 4'b0110; in_output[1] = 32'sd7; in_output[2] = 32'sd9;
    #1;
`ifdef ARRAY_OUTPUT_FIFO_BYPASS_EN
    checks++; if (out_valid !== 1'b1 || out_output !== 32'sd7) begin errors++; $display("FAIL bypass_same_cycle: got v=%0b d=%0d expected v=1 d=7", out_valid, out_output); end
    cyc(); clear_inputs(); #1;
    checks++; if (out_output !== 32'sd9 || count !== 4'd1) begin errors++; $display("FAIL bypass_next: got d=%0d count=%0d expected d=9 count=1", out_output, count); end
`else
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL nobypass_same_cycle: got %0b expected 0", out_valid); end
    cyc(); clear_inputs(); #1;
    checks++; if (out_output !== 32'sd7 || count !== 4'd2) begin errors++; $display("FAIL nobypass_first: got d=%0d count=%0d expected d=7 count=2", out_output, count); end
    cyc(); #1;
    checks++; if (out_output !== 32'sd9 || count !== 4'd1) begin errors++; $display("FAIL nobypass_second: got d=%0d count=%0d expected d=9 count=1", out_output, count); end
`endif
    cyc(); out_ready = 1'b0; #1;
    checks++; if (count !== 4'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL bypass_empty: got count=%0d v=%0b expected 0 0", count, out_valid); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_compaction();
    test_backpressure();
    test_mid_reset();
    test_wraparound();
    test_flush();
    test_bypass();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
